// File: rtl/protection_pkg.sv
// Shared encodings for the drive-protection supervisor: FSM states,
// first-fault codes and the debounce counter width.
package protection_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        FF_NONE   = 3'd0,
        FF_MK     = 3'd1,
        FF_PANEL  = 3'd2,
        FF_DRIVER = 3'd3,
        FF_ADC    = 3'd4
    } first_fault_t;

    // Debounce counters are 8 bits, which bounds FILT_CNT to 1..255.
    localparam int FILT_W = 8;

    // Fixed priority when several sources qualify in the same cycle:
    // MCU link, then panel link, then drivers, then ADC windows.
    function automatic first_fault_t pick_first_fault(
        input logic mk,
        input logic panel,
        input logic drv,
        input logic adc_any
    );
        first_fault_t code;
        code = FF_NONE;
        if (mk)           code = FF_MK;
        else if (panel)   code = FF_PANEL;
        else if (drv)     code = FF_DRIVER;
        else if (adc_any) code = FF_ADC;
        return code;
    endfunction

endpackage

// File: rtl/adc_window_filter.sv
// Window comparator with consecutive-sample debounce for one ADC channel.
// qualified is combinational from the current sample and the count of
// preceding out-of-window samples, so the owner sees the fault on the
// FILT_CNT-th consecutive out-of-window edge.
module adc_window_filter
    import protection_pkg::*;
#(
    parameter int ADC_W    = 16,
    parameter int FILT_CNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ADC_W-1:0] sample,
    input  logic [ADC_W-1:0] hi,
    input  logic [ADC_W-1:0] lo,
    output logic             qualified
);

    localparam logic [FILT_W-1:0] TERM = FILT_W'(FILT_CNT - 1);

    logic              out_of_window;
    logic [FILT_W-1:0] cnt;

    // Limits themselves count as in-window.
    assign out_of_window = (sample > hi) || (sample < lo);
    assign qualified     = out_of_window && (cnt == TERM);

    // Count consecutive out-of-window samples; hold at the terminal value
    // so the channel stays qualified while the excursion persists.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (!out_of_window) begin
            cnt <= '0;
        end else if (cnt != TERM) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/protection_supervisor.sv
// Drive-protection supervisor and run sequencer. Gates the control
// algorithm and the modulator, and latches the first fault with its
// sources until reset.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | both gates off, waiting for a main_enable rising edge
// ARMED    | algorithm enabled, waiting for algorithm_run
// RUN      | algorithm and modulator enabled
// FAULT    | both gates off, fault sources frozen until reset
module protection_supervisor
    import protection_pkg::*;
#(
    parameter int N_ADC    = 3,
    parameter int ADC_W    = 16,
    parameter int N_DRV    = 4,
    parameter int FILT_CNT = 4,
    parameter logic [N_ADC*ADC_W-1:0] ADC_HI = {16'd3250, 16'd2800, 16'd2800},
    parameter logic [N_ADC*ADC_W-1:0] ADC_LO = {16'd850, 16'd1300, 16'd1300}
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   main_enable,
    input  logic                   algorithm_run,
    input  logic                   mk_timeout,
    input  logic                   panel_timeout,
    input  logic [15:0]            encoder,
    input  logic [N_ADC*ADC_W-1:0] adc,
    input  logic [N_DRV-1:0]       driver_err,
    output logic                   algorithm_enable,
    output logic                   svm_enable,
    output logic [N_ADC-1:0]       adc_err,
    output logic [N_DRV-1:0]       igbt_err,
    output logic                   fault,
    output logic [2:0]             first_fault,
    output logic [1:0]             state
);

    localparam logic [N_DRV-1:0] DRV_OK = '1;

    state_t           state_q;
    state_t           state_n;
    first_fault_t     first_fault_q;
    logic [N_ADC-1:0] adc_qual;
    logic             drv_fault;
    logic             any_fault;
    logic             main_enable_d;
    logic             edge_valid;
    logic             arm_edge;
    logic             fault_entry;

    for (genvar i = 0; i < N_ADC; i++) begin : g_adc_filt
        adc_window_filter #(
            .ADC_W    (ADC_W),
            .FILT_CNT (FILT_CNT)
        ) u_adc_window_filter (
            .clk       (clk),
            .reset     (reset),
            .sample    (adc[i*ADC_W +: ADC_W]),
            .hi        (ADC_HI[i*ADC_W +: ADC_W]),
            .lo        (ADC_LO[i*ADC_W +: ADC_W]),
            .qualified (adc_qual[i])
        );
    end

    assign drv_fault = (driver_err != DRV_OK);
    assign any_fault = mk_timeout || panel_timeout || drv_fault || (|adc_qual);

    // The first cycle after reset has no trustworthy previous sample, so a
    // main_enable held high through reset must toggle before it can arm.
    assign arm_edge    = edge_valid && main_enable && !main_enable_d;
    assign fault_entry = (state_q != ST_FAULT) && (state_n == ST_FAULT);

    // Next-state decode; a qualifying fault overrides every other request.
    always_comb begin
        state_n = state_q;
        if (state_q != ST_FAULT && any_fault) begin
            state_n = ST_FAULT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm_edge && encoder == 16'd0) state_n = ST_ARMED;
                end
                ST_ARMED: begin
                    if (!main_enable)       state_n = ST_IDLE;
                    else if (algorithm_run) state_n = ST_RUN;
                end
                ST_RUN: begin
                    if (!main_enable) state_n = ST_IDLE;
                end
                ST_FAULT: state_n = ST_FAULT;
                default:  state_n = ST_IDLE;
            endcase
        end
    end

    // State register, registered gate outputs and fault-source latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            main_enable_d    <= 1'b0;
            edge_valid       <= 1'b0;
            algorithm_enable <= 1'b0;
            svm_enable       <= 1'b0;
            fault            <= 1'b0;
            adc_err          <= '0;
            igbt_err         <= '1;
            first_fault_q    <= FF_NONE;
        end else begin
            state_q          <= state_n;
            main_enable_d    <= main_enable;
            edge_valid       <= 1'b1;
            algorithm_enable <= (state_n == ST_ARMED) || (state_n == ST_RUN);
            svm_enable       <= (state_n == ST_RUN);
            fault            <= (state_n == ST_FAULT);
            if (fault_entry) begin
                adc_err       <= adc_qual;
                igbt_err      <= driver_err;
                first_fault_q <= pick_first_fault(mk_timeout, panel_timeout,
                                                  drv_fault, |adc_qual);
            end
        end
    end

    assign state       = state_q;
    assign first_fault = first_fault_q;

endmodule

// File: tb/tb_protection_supervisor.sv
// Directed bench for protection_supervisor with a scoreboard: each stimulus
// step queues the outputs expected after the next clock edge, and a
// separate monitor pops and compares them shortly after that edge.
module tb_protection_supervisor;

    localparam logic [1:0] S_I = 2'd0;
    localparam logic [1:0] S_A = 2'd1;
    localparam logic [1:0] S_R = 2'd2;
    localparam logic [1:0] S_F = 2'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic        main_enable;
    logic        algorithm_run;
    logic        mk_timeout;
    logic        panel_timeout;
    logic [15:0] encoder;
    logic [47:0] adc;
    logic [3:0]  driver_err;
    logic        algorithm_enable;
    logic        svm_enable;
    logic [2:0]  adc_err;
    logic [3:0]  igbt_err;
    logic        fault;
    logic [2:0]  first_fault;
    logic [1:0]  state;

    typedef struct packed {
        logic       alg_en;
        logic       svm_en;
        logic       flt;
        logic [2:0] adc_e;
        logic [3:0] igbt_e;
        logic [2:0] ff;
        logic [1:0] st;
    } resp_t;

    resp_t exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad   = 0;

    protection_supervisor dut (
        .clk              (clk),
        .reset            (reset),
        .main_enable      (main_enable),
        .algorithm_run    (algorithm_run),
        .mk_timeout       (mk_timeout),
        .panel_timeout    (panel_timeout),
        .encoder          (encoder),
        .adc              (adc),
        .driver_err       (driver_err),
        .algorithm_enable (algorithm_enable),
        .svm_enable       (svm_enable),
        .adc_err          (adc_err),
        .igbt_err         (igbt_err),
        .fault            (fault),
        .first_fault      (first_fault),
        .state            (state)
    );

    always #5 clk = ~clk;

    function automatic resp_t mk_resp(logic [1:0] st, logic [2:0] ae,
                                      logic [3:0] ig, logic [2:0] ff);
        resp_t r;
        r.alg_en = (st == S_A) || (st == S_R);
        r.svm_en = (st == S_R);
        r.flt    = (st == S_F);
        r.adc_e  = ae;
        r.igbt_e = ig;
        r.ff     = ff;
        r.st     = st;
        return r;
    endfunction

    // Queue the response expected after the coming edge, then let it pass.
    task automatic tick(string nm, logic [1:0] st, logic [2:0] ae,
                        logic [3:0] ig, logic [2:0] ff);
        exp_q.push_back(mk_resp(st, ae, ig, ff));
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    task automatic set_adc(logic [15:0] a0, logic [15:0] a1, logic [15:0] a2);
        adc = {a2, a1, a0};
    endtask

    // Monitor: compare a popped expectation 2 ns after each rising edge.
    initial begin
        resp_t e;
        resp_t got;
        string nm;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                got = {algorithm_enable, svm_enable, fault, adc_err,
                       igbt_err, first_fault, state};
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL %s: got st=%0d alg=%b svm=%b flt=%b adc_err=%b igbt=%b ff=%0d, want st=%0d alg=%b svm=%b flt=%b adc_err=%b igbt=%b ff=%0d",
                             nm, got.st, got.alg_en, got.svm_en, got.flt, got.adc_e,
                             got.igbt_e, got.ff, e.st, e.alg_en, e.svm_en, e.flt,
                             e.adc_e, e.igbt_e, e.ff);
                end
            end
        end
    end

    initial begin
        reset         = 1'b1;
        main_enable   = 1'b0;
        algorithm_run = 1'b0;
        mk_timeout    = 1'b0;
        panel_timeout = 1'b0;
        encoder       = 16'd0;
        driver_err    = 4'hF;
        set_adc(16'd2000, 16'd2000, 16'd2000);
        @(negedge clk);

        tick("reset_0", S_I, 3'b000, 4'hF, 3'd0);
        tick("reset_1", S_I, 3'b000, 4'hF, 3'd0);

        // Arm / run / stop, with the encoder interlock.
        reset = 1'b0;
        tick("idle", S_I, 3'b000, 4'hF, 3'd0);
        encoder = 16'd5; main_enable = 1'b1;
        tick("encoder_block", S_I, 3'b000, 4'hF, 3'd0);
        main_enable = 1'b0;
        tick("idle_low", S_I, 3'b000, 4'hF, 3'd0);
        encoder = 16'd0; main_enable = 1'b1;
        tick("arm", S_A, 3'b000, 4'hF, 3'd0);
        algorithm_run = 1'b1;
        tick("run", S_R, 3'b000, 4'hF, 3'd0);
        main_enable = 1'b0;
        tick("stop", S_I, 3'b000, 4'hF, 3'd0);
        algorithm_run = 1'b0; main_enable = 1'b1;
        tick("rearm", S_A, 3'b000, 4'hF, 3'd0);
        algorithm_run = 1'b1;
        tick("run2", S_R, 3'b000, 4'hF, 3'd0);

        // Samples sitting exactly on a limit never fault.
        set_adc(16'd1300, 16'd2800, 16'd850);
        for (int i = 0; i < 5; i++) tick("limit_eq_a", S_R, 3'b000, 4'hF, 3'd0);
        set_adc(16'd2800, 16'd1300, 16'd3250);
        for (int i = 0; i < 5; i++) tick("limit_eq_b", S_R, 3'b000, 4'hF, 3'd0);

        // Debounce: three out, one in, then four out.
        set_adc(16'd2000, 16'd2801, 16'd2000);
        for (int i = 0; i < 3; i++) tick("deb_pre", S_R, 3'b000, 4'hF, 3'd0);
        set_adc(16'd2000, 16'd2000, 16'd2000);
        tick("deb_break", S_R, 3'b000, 4'hF, 3'd0);
        set_adc(16'd2000, 16'd2801, 16'd2000);
        for (int i = 0; i < 3; i++) tick("deb_count", S_R, 3'b000, 4'hF, 3'd0);
        tick("adc_fault", S_F, 3'b010, 4'hF, 3'd4);
        set_adc(16'd2000, 16'd2000, 16'd2000);
        mk_timeout = 1'b1;
        tick("fault_frozen", S_F, 3'b010, 4'hF, 3'd4);
        mk_timeout = 1'b0;

        // Reset with main_enable held high: no re-arm until it toggles.
        reset = 1'b1;
        tick("reset_fault", S_I, 3'b000, 4'hF, 3'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick("no_rearm", S_I, 3'b000, 4'hF, 3'd0);
        main_enable = 1'b0;
        tick("toggle_low", S_I, 3'b000, 4'hF, 3'd0);
        main_enable = 1'b1;
        tick("toggle_arm", S_A, 3'b000, 4'hF, 3'd0);
        tick("toggle_run", S_R, 3'b000, 4'hF, 3'd0);

        // Simultaneous MCU timeout and driver fault; later ADC fault ignored.
        mk_timeout = 1'b1; driver_err = 4'b1101;
        tick("simul_fault", S_F, 3'b000, 4'b1101, 3'd1);
        mk_timeout = 1'b0; driver_err = 4'hF;
        set_adc(16'd2000, 16'd2801, 16'd2000);
        for (int i = 0; i < 4; i++) tick("simul_frozen", S_F, 3'b000, 4'b1101, 3'd1);

        // Two channels qualifying together, detected while IDLE.
        reset = 1'b1; main_enable = 1'b0; algorithm_run = 1'b0;
        set_adc(16'd2000, 16'd2000, 16'd2000);
        tick("reset_multi", S_I, 3'b000, 4'hF, 3'd0);
        reset = 1'b0;
        tick("idle_multi", S_I, 3'b000, 4'hF, 3'd0);
        set_adc(16'd1299, 16'd2000, 16'd3251);
        for (int i = 0; i < 3; i++) tick("multi_pre", S_I, 3'b000, 4'hF, 3'd0);
        tick("multi_fault", S_F, 3'b101, 4'hF, 3'd4);

        // Panel timeout outranks a driver fault in the same cycle.
        reset = 1'b1;
        set_adc(16'd2000, 16'd2000, 16'd2000);
        tick("reset_panel", S_I, 3'b000, 4'hF, 3'd0);
        reset = 1'b0;
        tick("idle_panel", S_I, 3'b000, 4'hF, 3'd0);
        panel_timeout = 1'b1; driver_err = 4'b0111;
        tick("panel_fault", S_F, 3'b000, 4'b0111, 3'd2);
        panel_timeout = 1'b0; driver_err = 4'hF;

        // A driver fault beats an arming edge in the same cycle.
        reset = 1'b1;
        tick("reset_drv", S_I, 3'b000, 4'hF, 3'd0);
        reset = 1'b0;
        tick("idle_drv", S_I, 3'b000, 4'hF, 3'd0);
        main_enable = 1'b1; driver_err = 4'b1110;
        tick("fault_beats_arm", S_F, 3'b000, 4'b1110, 3'd3);
        driver_err = 4'hF;

        @(negedge clk);
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/protection_supervisor.md
# protection_supervisor

Parametrised drive-protection supervisor and run sequencer. It sits between the host/panel control path and the SVM/vector-control pipeline, and gates `algorithm_enable` and `svm_enable`. It monitors N ADC channels against per-channel window limits with consecutive-sample debounce, plus per-leg IGBT driver faults and the communication timeouts. It latches the first fault and its sources until a synchronous reset.

## Interface
Parameters:
- `N_ADC`, 3: number of monitored ADC channels (1..8).
- `ADC_W`, 16: ADC sample width.
- `N_DRV`, 4: number of driver fault lines.
- `FILT_CNT`, 4: consecutive out-of-window samples needed to qualify an ADC fault (1..255; 1 means immediate).
- `ADC_HI`, {16'd3250,16'd2800,16'd2800}: packed upper limits; channel i is `[i*ADC_W +: ADC_W]`.
- `ADC_LO`, {16'd850,16'd1300,16'd1300}: packed lower limits, same packing.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high; clock `clk`.
- `main_enable` in 1: run request. A rising edge arms; low stops.
- `algorithm_run` in 1: control algorithm ready.
- `mk_timeout` in 1: MCU link timeout.
- `panel_timeout` in 1: panel link timeout.
- `encoder` in 16: position. Must be zero to arm.
- `adc` in N_ADC*ADC_W: packed unsigned samples.
- `driver_err` in N_DRV: active-low driver status; all-ones means OK.
- `algorithm_enable` out 1: algorithm gate.
- `svm_enable` out 1: modulator gate.
- `adc_err` out N_ADC: latched ADC fault sources.
- `igbt_err` out N_DRV: latched `driver_err` snapshot, active-low.
- `fault` out 1: high while in FAULT.
- `first_fault` out 3: 0 none, 1 mk_timeout, 2 panel_timeout, 3 driver, 4 ADC.
- `state` out 2: current state, for debug.

## Operation
States:
- IDLE: both enables 0.
- ARMED: `algorithm_enable`=1.
- RUN: `algorithm_enable`=1, `svm_enable`=1.
- FAULT: both enables 0.

Transitions:
- IDLE→ARMED: `main_enable` rising edge (registered `main_enable_d` = 0, `main_enable` = 1), `encoder`==0, and no fault qualifying this cycle.
- ARMED→RUN: `algorithm_run`=1.
- ARMED/RUN→IDLE: `main_enable`=0.
- Any state→FAULT: a fault qualifies. FAULT is left only via `reset`, which goes to IDLE. Re-arming after reset needs a fresh `main_enable` rising edge.

ADC window check, channel i:
- Out-of-window means sample > HI or sample < LO, unsigned. Equal to a limit is in-window.
- The 8-bit debounce counter increments on each out-of-window sample and clears on any in-window sample.
- The channel qualifies when out-of-window and counter == FILT_CNT-1. The counter saturates.

Driver and timeouts:
- Driver fault: `driver_err` != all-ones. Qualifies immediately.
- Timeouts: qualify immediately.

Fault entry:
- Faults are checked in every state, including IDLE.
- On entry, `adc_err` takes all channels qualifying that cycle and `igbt_err` takes the raw `driver_err`.
- `first_fault` takes the highest-priority source that cycle: mk > panel > driver > ADC.
- While in FAULT these outputs freeze; later faults are ignored.

Precedence and reset:
- Fault qualification beats `main_enable` and `algorithm_run` in the same cycle.
- `reset` beats everything.

Reset values:
- Enables 0, `fault` 0, `adc_err` 0, `igbt_err` all-ones, `first_fault` 0, `state` IDLE.
- Debounce counters and `main_enable_d` clear to 0.

## Timing
- All outputs are registered. A state change is visible 1 cycle after the qualifying input edge.
- Timeout or driver fault sampled at edge t: `svm_enable`=0 and `fault`=1 after edge t.
- ADC fault: visible after the FILT_CNT-th consecutive out-of-window sampling edge. A single in-window sample restarts the count.
- `main_enable` rise sampled at t: ARMED after t. `algorithm_run` sampled at t+1: RUN after t+1.
- `reset` mid-RUN: enables low after the reset edge. Counters restart from 0.

## Structure
- `protection_pkg` holds state encodings, `first_fault` codes and the `FILT_CNT` counter width.
- One sub-module, `adc_window_filter` (parameters ADC_W, FILT_CNT; inputs sample, hi, lo; output qualified). It is instantiated N_ADC times via generate.
- The top level holds the FSM, edge detector and latches.

## Test plan
- Arm/run: encoder=0, `main_enable` 0→1, `algorithm_run`=1 next cycle → ARMED then RUN. Encoder=5 → stays IDLE.
- ADC debounce, FILT_CNT=4: ADC1=2801 for 3 cycles, then 2000, then 2801 ×4 → no fault until the 4th consecutive sample. Then `adc_err`=3'b010, `first_fault`=4, `svm_enable`=0. ADC1=2800 → never a fault.
- Simultaneous: `mk_timeout`=1 and `driver_err`=4'b1101 in the same cycle during RUN → `first_fault`=1, `igbt_err`=4'b1101. A later ADC fault leaves `adc_err`=0.
- Multi-channel: ADC0=1299 and ADC2=3251 qualify in the same cycle → `adc_err`=3'b101.
- Reset: `reset` in FAULT → IDLE, `igbt_err`=4'hF. With `main_enable` held high there is no re-arm until it toggles.
- Stop: `main_enable` 1→0 in RUN → IDLE next cycle, `fault` stays 0.
